rf_wb_arb: RTL and testbench

RF_WB_ARB -- requirements
Module: rf_wb_arb

---
 rtl/rf_wb_arb.sv | 127 ++++++++++++
 tb/tb_rf_wb_arb.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arb.sv
// rtl/rf_wb_arb.sv - two-requester register-file writeback arbiter with busy scoreboard (option: RF_WB_FIXED_PRIO_EN)
module rf_wb_arb (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req0_valid_i,
  input  logic [4:0]  req0_rd_i,
  input  logic [31:0] req0_data_i,
  output logic        req0_ready_o,
  input  logic        req1_valid_i,
  input  logic [4:0]  req1_rd_i,
  input  logic [31:0] req1_data_i,
  output logic        req1_ready_o,
  input  logic        rsv_valid_i,
  input  logic [4:0]  rsv_rd_i,
  input  logic [4:0]  chk_rs1_i,
  input  logic [4:0]  chk_rs2_i,
  output logic        rs1_busy_o,
  output logic        rs2_busy_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_wR_o,
  output logic [31:0] rf_wD_o,
  output logic        err_o
);

  logic [31:1] busy;
  logic [31:1] busy_nxt;
  logic [31:0] busy_full;
  logic        grant0;
  logic        grant1;
  logic        xfer;
  logic [4:0]  sel_rd;
  logic [31:0] sel_data;
  logic        unreserved;

  assign busy_full = {busy, 1'b0};

`ifdef RF_WB_FIXED_PRIO_EN
  // Fixed priority: the load/multi-cycle path always beats the ALU path.
  always_comb begin
    grant1 = req1_valid_i;
    grant0 = req0_valid_i & ~req1_valid_i;
  end
`else
  logic ptr;

  // Round-robin: a lone requester always wins, otherwise ptr picks the winner.
  always_comb begin
    grant0 = req0_valid_i & (~req1_valid_i | ~ptr);
    grant1 = req1_valid_i & (~req0_valid_i | ptr);
  end

  // Pointer moves to the requester that did not just win; holds when idle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr <= 1'b0;
    end else if (grant0) begin
      ptr <= 1'b1;
    end else if (grant1) begin
      ptr <= 1'b0;
    end
  end
`endif

  // Ready is forced low while reset is asserted so nothing is accepted then.
  assign req0_ready_o = grant0 & rst_n_i;
  assign req1_ready_o = grant1 & rst_n_i;
  assign xfer         = req0_ready_o | req1_ready_o;
  assign sel_rd       = req1_ready_o ? req1_rd_i : req0_rd_i;
  assign sel_data     = req1_ready_o ? req1_data_i : req0_data_i;

  // A commit is flagged when its destination was never reserved (same-cycle reservation counts).
  assign unreserved = xfer && (sel_rd != 5'd0) && !busy_full[sel_rd]
                      && !(rsv_valid_i && (rsv_rd_i == sel_rd));

  // Hazard query: scoreboard bit, plus the write currently sitting in the output stage.
  always_comb begin
    rs1_busy_o = busy_full[chk_rs1_i] | (rf_we_o && (rf_wR_o == chk_rs1_i) && (chk_rs1_i != 5'd0));
    rs2_busy_o = busy_full[chk_rs2_i] | (rf_we_o && (rf_wR_o == chk_rs2_i) && (chk_rs2_i != 5'd0));
  end

  // Next scoreboard: clear on the landing RF write, set on reservation; set wins.
  always_comb begin
    busy_nxt = busy;
    for (int i = 1; i < 32; i++) begin
      if (rf_we_o && (rf_wR_o == 5'(i))) begin
        busy_nxt[i] = 1'b0;
      end
      if (rsv_valid_i && (rsv_rd_i == 5'(i))) begin
        busy_nxt[i] = 1'b1;
      end
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Output stage: one-cycle registered RF write; x0 commits are swallowed.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rf_we_o <= 1'b0;
      rf_wR_o <= 5'd0;
      rf_wD_o <= 32'd0;
    end else begin
      rf_we_o <= xfer && (sel_rd != 5'd0);
      if (xfer) begin
        rf_wR_o <= sel_rd;
        rf_wD_o <= sel_data;
      end
    end
  end

  // Sticky error for a commit to a register that was not reserved.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_o <= 1'b0;
    end else if (unreserved) begin
      err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rf_wb_arb.sv
// tb/tb_rf_wb_arb.sv - self-checking bench for rf_wb_arb
module tb_rf_wb_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0;
  logic [4:0]  req0_rd = '0;
  logic [31:0] req0_data = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [4:0]  req1_rd = '0;
  logic [31:0] req1_data = '0;
  logic        req1_ready;
  logic        rsv_valid = 1'b0;
  logic [4:0]  rsv_rd = '0;
  logic [4:0]  chk_rs1 = '0;
  logic [4:0]  chk_rs2 = '0;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        rf_we;
  logic [4:0]  rf_wr;
  logic [31:0] rf_wd;
  logic        err;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic        v0;
    logic [4:0]  rd0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  rd1;
    logic [31:0] d1;
    logic        rv;
    logic [4:0]  rr;
    logic        e0;
    logic        e1;
  } vec_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] d;
  } wr_t;

  wr_t  sb[$];
  vec_t tbl[10];

  rf_wb_arb dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .req0_valid_i (req0_valid),
    .req0_rd_i    (req0_rd),
    .req0_data_i  (req0_data),
    .req0_ready_o (req0_ready),
    .req1_valid_i (req1_valid),
    .req1_rd_i    (req1_rd),
    .req1_data_i  (req1_data),
    .req1_ready_o (req1_ready),
    .rsv_valid_i  (rsv_valid),
    .rsv_rd_i     (rsv_rd),
    .chk_rs1_i    (chk_rs1),
    .chk_rs2_i    (chk_rs2),
    .rs1_busy_o   (rs1_busy),
    .rs2_busy_o   (rs2_busy),
    .rf_we_o      (rf_we),
    .rf_wR_o      (rf_wr),
    .rf_wD_o      (rf_wd),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsv_valid  = 1'b0;
    req0_rd    = '0;
    req1_rd    = '0;
    rsv_rd     = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
  endtask

  // One cycle: drive at negedge, check readies, score the expected write, check it after the edge.
  task automatic cyc(input logic v0, input logic [4:0] rd0, input logic [31:0] d0,
                     input logic v1, input logic [4:0] rd1, input logic [31:0] d1,
                     input logic rv, input logic [4:0] rr, input logic e0, input logic e1);
    wr_t w;
    @(negedge clk);
    req0_valid = v0; req0_rd = rd0; req0_data = d0;
    req1_valid = v1; req1_rd = rd1; req1_data = d1;
    rsv_valid  = rv; rsv_rd  = rr;
    #1;
    chk("req0_ready", 32'(req0_ready), 32'(e0));
    chk("req1_ready", 32'(req1_ready), 32'(e1));
    if (e0)      sb.push_back('{we: (rd0 != 5'd0), rd: rd0, d: d0});
    else if (e1) sb.push_back('{we: (rd1 != 5'd0), rd: rd1, d: d1});
    else         sb.push_back('{we: 1'b0, rd: 5'd0, d: 32'd0});
    @(posedge clk);
    #1;
    w = sb.pop_front();
    chk("rf_we", 32'(rf_we), 32'(w.we));
    if (w.we) begin
      chk("rf_wR", 32'(rf_wr), 32'(w.rd));
      chk("rf_wD", rf_wd, w.d);
    end
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    // Arbitration table: rsv x3, x4, then both valid for four cycles, then lone requesters.
    tbl[0] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0, 1'b0};
`ifdef RF_WB_FIXED_PRIO_EN
    tbl[2] = '{1'b1, 5'd3, 32'hA0, 1'b1, 5'd4, 32'hB0, 1'b0, 5'd0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 5'd3, 32'hA1, 1'b1, 5'd4, 32'hB1, 1'b0, 5'd0, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 5'd3, 32'hA2, 1'b1, 5'd4, 32'hB2, 1'b0, 5'd0, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 5'd3, 32'hA3, 1'b1, 5'd4, 32'hB3, 1'b0, 5'd0, 1'b0, 1'b1};
`else
    tbl[2] = '{1'b1, 5'd3, 32'hA0, 1'b1, 5'd4, 32'hB0, 1'b0, 5'd0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 5'd3, 32'hA1, 1'b1, 5'd4, 32'hB1, 1'b0, 5'd0, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 5'd3, 32'hA2, 1'b1, 5'd4, 32'hB2, 1'b0, 5'd0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 5'd3, 32'hA3, 1'b1, 5'd4, 32'hB3, 1'b0, 5'd0, 1'b0, 1'b1};
`endif
    tbl[6] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'hC0, 1'b0, 5'd0, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 5'd3, 32'hC1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0};
    tbl[9] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 1'b0, 1'b1};

    // Reset state, with both requesters asserting valid.
    req0_valid = 1'b1; req0_rd = 5'd1;
    req1_valid = 1'b1; req1_rd = 5'd2;
    #13;
    chk("reset_ready0", 32'(req0_ready), 32'd0);
    chk("reset_ready1", 32'(req1_ready), 32'd0);
    chk("reset_we", 32'(rf_we), 32'd0);
    chk("reset_wR", 32'(rf_wr), 32'd0);
    chk("reset_wD", rf_wd, 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    do_reset();

    // Reserve x5, commit x5, watch the hazard bit fall after the write lands.
    chk_rs1 = 5'd5;
    chk_rs2 = 5'd0;
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b0, 1'b0);
    chk("rs1_busy_after_rsv", 32'(rs1_busy), 32'd1);
    cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    chk("rs1_busy_write_pending", 32'(rs1_busy), 32'd1);
    idle_cyc();
    chk("rs1_busy_after_write", 32'(rs1_busy), 32'd0);
    chk("rs2_busy_x0", 32'(rs2_busy), 32'd0);
    chk("err_reserved_commit", 32'(err), 32'd0);

    // Table-driven arbitration from a fresh pointer.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].v0, tbl[i].rd0, tbl[i].d0, tbl[i].v1, tbl[i].rd1, tbl[i].d1,
          tbl[i].rv, tbl[i].rr, tbl[i].e0, tbl[i].e1);
    end

    // Same-edge reservation and write-landing of x7 keeps it busy.
    do_reset();
    chk_rs1 = 5'd7;
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 1'b0);
    cyc(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 1'b0);
    idle_cyc();
    chk("x7_busy_set_wins", 32'(rs1_busy), 32'd1);
    chk("x7_err", 32'(err), 32'd0);

    // Commit to x0 is accepted but never written.
    cyc(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    idle_cyc();
    chk("x0_err", 32'(err), 32'd0);

    // Unreserved commit to x9 via req1: sticky error, write still lands.
    chk_rs2 = 5'd9;
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 1'b0, 1'b1);
    chk("x9_err_set", 32'(err), 32'd1);
    chk("x9_busy_pending", 32'(rs2_busy), 32'd1);
    for (int i = 0; i < 10; i++) begin
      idle_cyc();
      chk("x9_err_sticky", 32'(err), 32'd1);
    end

    // Reset mid-cycle with a staged write.
    do_reset();
    chk_rs1 = 5'd6;
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 1'b0, 1'b0);
    cyc(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_we", 32'(rf_we), 32'd0);
    chk("midreset_busy", 32'(rs1_busy), 32'd0);
    chk("midreset_err", 32'(err), 32'd0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      idle_cyc();
    end
    chk("postreset_busy", 32'(rs1_busy), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
